// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorting-cell chain feeder.
// Holds the feeder state encoding and counter sizing helper.
package sort_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_DEF     = 8;
    localparam int FLUSH_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } feed_state_e;

    // Bits needed to hold a count from 0 up to and including depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sort_feeder_if.sv
// Bundle of the feeder's control, input stream and chain broadcast signals.
// master drives the stream into the feeder; slave is the feeder itself.
interface sort_feeder_if
    import sort_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = cnt_w(DEPTH_DEF)
) ();

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              chain_clr;
    logic              sort_en;
    logic [DATA_W-1:0] new_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, chain_clr, sort_en, new_data,
        input  busy, done, count, overflow
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, chain_clr, sort_en, new_data,
        output busy, done, count, overflow
    );

endinterface

// File: rtl/sort_feeder.sv
// Feeds one batch of words into the sorting-cell chain, one per enable.
// Clears the chain first, caps the batch at DEPTH, then waits for it to settle.
module sort_feeder
    import sort_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
    input  logic         clk,
    input  logic         rst,
    sort_feeder_if.slave bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYC + 2);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [FC_W-1:0]  FLUSH_C  = FC_W'(FLUSH_CYC);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

    feed_state_e       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              sort_en_q, sort_en_d;
    logic [DATA_W-1:0] new_data_q, new_data_d;
    logic [FC_W-1:0]   flush_q, flush_d;

    logic in_ready;
    logic xfer;

    assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign xfer     = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.chain_clr = (state_q == ST_CLEAR);
    assign bus.sort_en   = sort_en_q;
    assign bus.new_data  = new_data_q;
    assign bus.busy      = (state_q == ST_CLEAR) ||
                           (state_q == ST_LOAD)  ||
                           (state_q == ST_FLUSH);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;

    // Next-state, word counter, broadcast register and settle timer.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        sort_en_d  = 1'b0;
        new_data_d = new_data_q;
        flush_d    = flush_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d    = ST_CLEAR;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_LOAD;
                count_d    = '0;
                overflow_d = 1'b0;
            end
            ST_LOAD: begin
                if (xfer) begin
                    sort_en_d  = 1'b1;
                    new_data_d = bus.in_data;
                    count_d    = count_q + CNT_ONE;
                    if (bus.in_last) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end else if (count_q == DEPTH_M1) begin
                        state_d    = ST_FLUSH;
                        flush_d    = '0;
                        overflow_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_C) begin
                    state_d = ST_DONE;
                end else begin
                    flush_d = flush_q + FC_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any batch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sort_en_q  <= 1'b0;
            new_data_q <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sort_en_q  <= sort_en_d;
            new_data_q <= new_data_d;
            flush_q    <= flush_d;
        end
    end

endmodule

// File: tb/tb_sort_feeder.sv
// Directed bench for sort_feeder with a scoreboard of broadcast words.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_sort_feeder;
    import sort_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = cnt_w(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [DW-1:0] sb[$];
    int            pulse_cyc[$];
    logic [DW-1:0] exp_w;

    sort_feeder_if #(.DATA_W(DW), .CNT_W(CW)) f ();

    sort_feeder #(
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .FLUSH_CYC(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(f.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every enable pulse must carry the next expected word.
    always @(negedge clk) begin
        if (f.sort_en === 1'b1) begin
            check("sb_underflow", 64'(sb.size() != 0), 64'd1);
            check("clr_and_en", 64'(f.chain_clr), 64'd0);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("new_data", 64'(f.new_data), 64'(exp_w));
            end
            pulse_cyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] outs();
        return 64'({f.in_ready, f.chain_clr, f.sort_en, f.new_data,
                    f.busy, f.done, f.count, f.overflow});
    endfunction

    task automatic start_batch();
        f.start = 1'b1;
        @(posedge clk); #1;
        f.start = 1'b0;
        @(negedge clk);
        check("chain_clr", 64'(f.chain_clr), 64'd1);
        check("clr_count", 64'(f.count), 64'd0);
        check("clr_done", 64'(f.done), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        logic hs;
        int   w;
        hs = 1'b0;
        w  = 0;
        f.in_valid = 1'b1;
        f.in_data  = d;
        f.in_last  = l;
        do begin
            @(negedge clk);
            hs = f.in_ready;
            @(posedge clk); #1;
            w++;
        end while (!hs && w < 20);
        check("handshake", 64'(hs), 64'd1);
        if (hs) sb.push_back(d);
        f.in_valid = 1'b0;
        f.in_last  = 1'b0;
    endtask

    // Idle one cycle, then confirm no enable and the broadcast word holds.
    task automatic gap(input logic [DW-1:0] hold);
        @(posedge clk); #1;
        @(negedge clk);
        check("gap_sort_en", 64'(f.sort_en), 64'd0);
        check("gap_hold", 64'(f.new_data), 64'(hold));
        @(posedge clk); #1;
    endtask

    // Called in the cycle of the final broadcast; done is due 4 negedges on.
    task automatic wait_done();
        int   lat;
        logic rdy;
        lat = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            rdy = rdy | f.in_ready;
        end while (f.done !== 1'b1 && lat < 40);
        check("done_latency", 64'(lat), 64'd4);
        check("flush_in_ready", 64'(rdy), 64'd0);
        check("done_busy", 64'(f.busy), 64'd0);
    endtask

    initial begin
        f.start    = 1'b0;
        f.in_valid = 1'b0;
        f.in_data  = '0;
        f.in_last  = 1'b0;

        // 1: reset, then idle with start low
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outs", outs(), 64'd0);
        end
        @(posedge clk); #1;

        // 2: back-to-back batch 5,3,7,1
        pulse_cyc.delete();
        start_batch();
        check("load_busy", 64'(f.busy), 64'd1);
        send(32'd5, 1'b0);
        send(32'd3, 1'b0);
        send(32'd7, 1'b0);
        send(32'd1, 1'b1);
        wait_done();
        check("b2_pulses", 64'(pulse_cyc.size()), 64'd4);
        check("b2_span", 64'(pulse_cyc[$] - pulse_cyc[0]), 64'd3);
        check("b2_count", 64'(f.count), 64'd4);
        check("b2_ovf", 64'(f.overflow), 64'd0);

        // 3: gaps between words 9,4,6
        start_batch();
        send(32'd9, 1'b0);
        gap(32'd9);
        send(32'd4, 1'b0);
        gap(32'd4);
        send(32'd6, 1'b1);
        wait_done();
        check("b3_count", 64'(f.count), 64'd3);
        check("b3_ovf", 64'(f.overflow), 64'd0);

        // 4: overflow, 10..3 accepted, 2 and 1 refused
        start_batch();
        for (int v = 10; v >= 3; v--) send(DW'(v), 1'b0);
        f.in_valid = 1'b1;
        f.in_data  = 32'd2;
        wait_done();
        f.in_data  = 32'd1;
        @(negedge clk);
        check("b4_in_ready", 64'(f.in_ready), 64'd0);
        f.in_valid = 1'b0;
        check("b4_count", 64'(f.count), 64'd8);
        check("b4_ovf", 64'(f.overflow), 64'd1);
        check("b4_done", 64'(f.done), 64'd1);

        // 5: exact fill with last on the 8th word, incl. zero and duplicates
        start_batch();
        check("b5_ovf_clr", 64'(f.overflow), 64'd0);
        for (int v = 0; v < 8; v++)
            send(DW'((v * 3) % 5), v == 7);
        wait_done();
        check("b5_count", 64'(f.count), 64'd8);
        check("b5_ovf", 64'(f.overflow), 64'd0);

        // 6: reset mid-load, then restart with an ignored start
        start_batch();
        send(32'd21, 1'b0);
        send(32'd22, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_outs", outs(), 64'd0);
        end
        @(posedge clk); #1;
        start_batch();
        send(32'd31, 1'b0);
        f.start = 1'b1;
        @(negedge clk);
        check("ign_clr0", 64'(f.chain_clr), 64'd0);
        @(posedge clk); #1;
        f.start = 1'b0;
        @(negedge clk);
        check("ign_clr1", 64'(f.chain_clr), 64'd0);
        check("ign_busy", 64'(f.busy), 64'd1);
        @(posedge clk); #1;
        send(32'd32, 1'b0);
        send(32'd33, 1'b1);
        wait_done();
        check("b6_count", 64'(f.count), 64'd3);
        check("b6_ovf", 64'(f.overflow), 64'd0);

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_feeder.md
Name: sort_feeder

Overview:
- Upstream stage of the sorting_cell chain.
- Accepts a valid/ready input stream of unsorted words and broadcasts them one at a time on the chain's shared new_data bus, qualified by the chain enable.
- Clears the chain before each batch, counts loaded words, and flags when the chain has settled and holds a sorted batch.
- Limits each batch to DEPTH words, the number of cells in the chain.

Parameters:
- DATA_W, 32, width of data words (matches cell data width).
- DEPTH, 8, number of sorting cells in the chain, i.e. maximum words per batch.
- CNT_W, $clog2(DEPTH+1), width of the word counter.
- FLUSH_CYC, 2, idle cycles after the last word before done asserts.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a new batch; sampled in IDLE and DONE only.
- in_valid  in  1  input word valid.
- in_ready  out  1  feeder can accept a word this cycle.
- in_data  in  DATA_W  input word.
- in_last  in  1  marks the final word of the batch.
- chain_clr  out  1  one-cycle synchronous clear pulse to all cells.
- sort_en  out  1  chain enable; high exactly one cycle per word broadcast.
- new_data  out  DATA_W  broadcast word to every cell's new_data.
- busy  out  1  high in CLEAR, LOAD and FLUSH.
- done  out  1  chain settled; held until next start or rst.
- count  out  CNT_W  number of words accepted in the current batch.
- overflow  out  1  DEPTH words accepted without in_last; sticky until next start.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, chain_clr, sort_en, new_data, busy, done, count, overflow.
  - rst mid-batch aborts the batch immediately; no further sort_en pulses are issued.
- States: IDLE, CLEAR, LOAD, FLUSH, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → CLEAR.
- CLEAR (1 cycle):
  - chain_clr=1, count←0, overflow←0, done←0.
  - Next state LOAD.
- LOAD:
  - in_ready = (count < DEPTH). It is combinational from state and count and does not depend on in_valid.
  - Transfer occurs on in_valid & in_ready at a posedge.
  - On the transfer edge: new_data←in_data, sort_en←1, count←count+1. Latency is 1 cycle: the word appears on new_data with sort_en=1 in the cycle after the handshake.
  - With no transfer: sort_en←0 and new_data holds its previous value.
  - Back-to-back transfers give sort_en high on consecutive cycles, one distinct word per cycle.
  - Transfer with in_last=1 → FLUSH.
  - Transfer that makes count==DEPTH with in_last=0 → overflow←1, then FLUSH. Further input is not consumed (in_ready=0). The upstream source is responsible for discarding the remainder.
  - Transfer with in_last=1 exactly at count==DEPTH → FLUSH with no overflow.
- FLUSH:
  - in_ready=0.
  - sort_en is high only in the first cycle (the final word's broadcast), then 0.
  - An internal counter runs FLUSH_CYC cycles after the final broadcast, then → DONE.
- DONE:
  - done=1, busy=0, count held.
  - start=1 → CLEAR, which clears done in the same cycle chain_clr pulses.
- start is ignored in CLEAR, LOAD and FLUSH.
- count never exceeds DEPTH and never wraps.
- Duplicate values and zero values are passed unchanged; ordering is the chain's responsibility.
- chain_clr and sort_en are never high in the same cycle.

Decomposition:
- Shared package sort_pkg:
  - DATA_W and DEPTH defaults.
  - feeder state enum (IDLE, CLEAR, LOAD, FLUSH, DONE).
  - CNT_W helper function.
- No sub-module is needed; the FSM, counter and output register live in one module.
- A separate top-level wrapper, sort_array, instantiates sort_feeder plus DEPTH sorting_cell instances. It ties cell 0's prev_state to 1 and connects chain_clr into each cell's rst.

Test Plan:
1. Reset then idle: rst for 2 cycles, start=0 for 5 cycles → all outputs 0, in_ready=0 throughout.
2. Normal batch, DEPTH=8: start, then words 5,3,7,1 back-to-back with in_last on 1 → chain_clr pulses 1 cycle after start; sort_en high 4 consecutive cycles with new_data 5,3,7,1, each 1 cycle after its handshake; count=4; done after FLUSH_CYC cycles; overflow=0.
3. Backpressure gaps: in_valid toggled 1,0,1,0,1 with words 9,4,6 (last on 6) → sort_en low during gap cycles; new_data holds 9 then 4 between pulses; count=3.
4. Overflow: 10 words 10..1 with no in_last → exactly 8 accepted (10..3); in_ready drops after the 8th; overflow=1; count=8; done asserts; words 2 and 1 are not consumed.
5. Exact fill: 8 words with in_last on the 8th → overflow=0, count=8, done=1.
6. Reset mid-LOAD, then restart: rst after 2 of 4 words → next cycle all outputs 0 and state IDLE. A later start runs a full batch correctly. start pulsed during LOAD is ignored, with no extra chain_clr.
